// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: fixed-latency word array with stall/ack handshake.
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] writedata_i,
  output logic [31:0] memdata_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     memdata_q, memdata_d;
  logic            wr_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     data_q;
  logic [31:0]     mem_q [DEPTH];

  logic            req;
  logic            cap_en;
  logic            do_access;
  logic [AW-1:0]   in_idx;
  logic            acc_wr;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_data;
  logic            acc_mis;
  logic            unused_addr;

  assign req         = memread_i | memwrite_i;
  assign in_idx      = addr_i[AW+1:2];
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  logic in_mis;
  logic mis_q;
  logic err_q;

  assign in_mis  = (addr_i[1:0] != 2'b00);
  assign acc_mis = (LATENCY == 1) ? in_mis : mis_q;
  assign err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (cap_en) mis_q <= in_mis;
  end

  // err_q is only ever set on the access edge, so it is high exactly in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= do_access & acc_mis;
  end
`else
  assign acc_mis = 1'b0;
  assign err_o   = 1'b0;
`endif

  // With LATENCY=1 the access happens on the accept edge, straight from the inputs.
  assign acc_wr   = (LATENCY == 1) ? memwrite_i  : wr_q;
  assign acc_idx  = (LATENCY == 1) ? in_idx      : idx_q;
  assign acc_data = (LATENCY == 1) ? writedata_i : data_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_en    = 1'b0;
    do_access = 1'b0;
    stall_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_o = 1'b1;
          cap_en  = 1'b1;
          if (LATENCY == 1) begin
            state_d   = DONE;
            do_access = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d   = DONE;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    memdata_d = memdata_q;
    if (do_access && !acc_wr && !acc_mis) memdata_d = mem_q[acc_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      memdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      memdata_q <= memdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cap_en) begin
      wr_q   <= memwrite_i;
      idx_q  <= in_idx;
      data_q <= writedata_i;
    end
  end

  // Reset cancels a write landing on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_access && acc_wr && !acc_mis) mem_q[acc_idx] <= acc_data;
  end

  assign memdata_o = memdata_q;
  assign ack_o     = (state_q == DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=256, LATENCY=3).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] memdata;
  logic        stall;
  logic        ack;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  int          stall_n;
  int          ack_cyc;
  logic [31:0] rdata;
  logic        rerr;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst), .memread_i(memread), .memwrite_i(memwrite),
    .addr_i(addr), .writedata_i(wdata), .memdata_o(memdata),
    .stall_o(stall), .ack_o(ack), .err_o(err)
  );

  // Issues one request in the next cycle and observes until ack (bounded); leaves inputs asserted.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    memread = rd; memwrite = wr; addr = a; wdata = d;
    stall_n = 0; ack_cyc = -1; rdata = 32'hDEAD_BEEF; rerr = 1'bx;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (ack) begin
        ack_cyc = c; rdata = memdata; rerr = err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; memread = 1'b1; memwrite = 1'b0; addr = 32'h10; wdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0; memread = 1'b0;
    @(negedge clk);
    n_cmp++; if (memdata !== 32'h0) begin n_bad++; $display("FAIL reset_memdata: got %h expected %h", memdata, 32'h0); end
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_idle_stall: got %b expected 0", stall); end
  endtask

  task automatic test_write_read();
    run_access(1'b0, 1'b1, 32'h10, 32'h1234_5678);
    n_cmp++; if (stall_n !== 3) begin n_bad++; $display("FAIL wr_stall_cycles: got %0d expected 3", stall_n); end
    n_cmp++; if (ack_cyc !== 3) begin n_bad++; $display("FAIL wr_ack_cycle: got %0d expected 3", ack_cyc); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL wr_memdata_unchanged: got %h expected %h", rdata, 32'h0); end
    n_cmp++; if (rerr !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b expected 0", rerr); end
    go_idle();
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL ack_one_cycle: got %b expected 0", ack); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0);
    n_cmp++; if (ack_cyc !== 3) begin n_bad++; $display("FAIL rd_ack_cycle: got %0d expected 3", ack_cyc); end
    n_cmp++; if (stall_n !== 3) begin n_bad++; $display("FAIL rd_stall_cycles: got %0d expected 3", stall_n); end
    n_cmp++; if (rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_data: got %h expected %h", rdata, 32'h1234_5678); end
    go_idle();
    n_cmp++; if (memdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_data_hold: got %h expected %h", memdata, 32'h1234_5678); end
  endtask

  task automatic test_wrap();
    run_access(1'b0, 1'b1, 32'h404, 32'hCAFE_F00D);
    go_idle();
    run_access(1'b1, 1'b0, 32'h004, 32'h0);
    n_cmp++; if (rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL wrap_data: got %h expected %h", rdata, 32'hCAFE_F00D); end
    go_idle();
  endtask

  task automatic test_read_write_both();
    run_access(1'b1, 1'b1, 32'h20, 32'h55AA_55AA);
    n_cmp++; if (rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL both_memdata_unchanged: got %h expected %h", rdata, 32'hCAFE_F00D); end
    n_cmp++; if (ack_cyc !== 3) begin n_bad++; $display("FAIL both_ack_cycle: got %0d expected 3", ack_cyc); end
    go_idle();
    run_access(1'b1, 1'b0, 32'h20, 32'h0);
    n_cmp++; if (rdata !== 32'h55AA_55AA) begin n_bad++; $display("FAIL both_readback: got %h expected %h", rdata, 32'h55AA_55AA); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int acks;
    run_access(1'b0, 1'b1, 32'h30, 32'h0000_0001);
    go_idle();
    acks = 0;
    @(posedge clk); #1;
    memwrite = 1'b1; addr = 32'h30; wdata = 32'hFFFF_FFFF;
    @(negedge clk); if (ack) acks++;
    @(posedge clk); #1;
    @(negedge clk); if (ack) acks++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); if (ack) acks++;
    @(posedge clk); #1;
    rst = 1'b0; memwrite = 1'b0;
    @(negedge clk); if (ack) acks++;
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL midrst_no_ack: got %0d acks expected 0", acks); end
    n_cmp++; if (memdata !== 32'h0) begin n_bad++; $display("FAIL midrst_memdata: got %h expected %h", memdata, 32'h0); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL midrst_stall: got %b expected 0", stall); end
    run_access(1'b1, 1'b0, 32'h30, 32'h0);
    n_cmp++; if (rdata !== 32'h0000_0001) begin n_bad++; $display("FAIL midrst_write_dropped: got %h expected %h", rdata, 32'h1); end
    go_idle();
  endtask

  task automatic test_misalign();
    run_access(1'b1, 1'b0, 32'h13, 32'h0);
    n_cmp++; if (ack_cyc !== 3) begin n_bad++; $display("FAIL mis_ack_cycle: got %0d expected 3", ack_cyc); end
`ifdef DMEM_MISALIGN_CHECK_EN
    n_cmp++; if (rdata !== 32'h0000_0001) begin n_bad++; $display("FAIL mis_memdata: got %h expected %h", rdata, 32'h1); end
    n_cmp++; if (rerr !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b expected 1", rerr); end
`else
    n_cmp++; if (rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL mis_memdata: got %h expected %h", rdata, 32'h1234_5678); end
    n_cmp++; if (rerr !== 1'b0) begin n_bad++; $display("FAIL mis_err: got %b expected 0", rerr); end
`endif
    go_idle();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mis_err_after_ack: got %b expected 0", err); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 32'h40, 32'h0000_000A);
    n_cmp++; if (ack_cyc !== 3) begin n_bad++; $display("FAIL b2b_first_ack: got %0d expected 3", ack_cyc); end
    run_access(1'b0, 1'b1, 32'h44, 32'h0000_000B);
    n_cmp++; if (ack_cyc !== 3) begin n_bad++; $display("FAIL b2b_second_ack: got %0d expected 3", ack_cyc); end
    n_cmp++; if (stall_n !== 3) begin n_bad++; $display("FAIL b2b_second_stall: got %0d expected 3", stall_n); end
    run_access(1'b1, 1'b0, 32'h40, 32'h0);
    n_cmp++; if (rdata !== 32'h0000_000A) begin n_bad++; $display("FAIL b2b_read40: got %h expected %h", rdata, 32'hA); end
    run_access(1'b1, 1'b0, 32'h44, 32'h0);
    n_cmp++; if (rdata !== 32'h0000_000B) begin n_bad++; $display("FAIL b2b_read44: got %h expected %h", rdata, 32'hB); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_read_write_both();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
